csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  Machine-mode CSR register file for the RV32I core. It serves two ports: the
//  Zicsr instruction port (CSRRW/S/C from execute/writeback) and the trap port
//  driven by TrapController, which reads mtvec/mepc and writes mepc/mcause/mstatus.
//  Sits directly downstream of TrapController and beside the register file.
// PARAMETERS
//  MTVEC_RESET  32'h0000_1000  reset value of mtvec (bits[1:0] forced 0)
//  HART_ID      32'h0000_0000  value returned by mhartid
// PORTS
//  clk                  in   1   core clock, all state updates on posedge
//  rst                  in   1   synchronous, active-high reset
//  csr_read_enable      in   1   instruction port read strobe (for illegal check)
//  csr_read_address     in   12  instruction port read address
//  csr_read_data        out  32  instruction port read data (combinational)
//  csr_write_enable     in   1   instruction port write strobe
//  csr_write_address    in   12  instruction port write address
//  csr_write_data       in   32  instruction port write data (already RW/S/C-merged)
//  csr_illegal          out  1   access to unimplemented or read-only CSR
//  csr_trap_address     in   12  trap port address (read and write)
//  csr_trap_write_enable in  1   trap port write strobe
//  csr_trap_write_data  in   32  trap port write data
//  csr_rd               out  32  trap port read data at csr_trap_address (combinational)
//  instret_inc          in   1   one instruction retired this cycle
// BEHAVIOUR
//  - Implemented: mstatus 300, misa 301 (RO 32'h4000_0100), mtvec 305, mscratch 340,
//    mepc 341, mcause 342, mtval 343, mvendorid F11/marchid F12/mimpid F13 (RO 0),
//    mhartid F14 (RO HART_ID). All other addresses unimplemented, read as 0.
//  - mstatus: only MIE[3], MPIE[7] writable; MPP[12:11] hardwired 2'b11; rest 0.
//  - mtvec, mepc: bits[1:0] forced 0 on write (direct mode, 4-byte aligned).
//  - Reset (rst=1 at posedge): mstatus=32'h0000_1800, mtvec=MTVEC_RESET, all other
//    writable CSRs and counters = 0. Outputs follow combinationally from state.
//  - Reads: combinational, zero latency on both ports; no write bypass -- a read of
//    an address written in the same cycle returns the old value.
//  - Writes: committed at posedge, visible next cycle. Latency 1.
//  - Both ports writing same address in one cycle: trap port wins, instruction write
//    dropped. Different addresses: both commit.
//  - csr_illegal=1 when (csr_read_enable & unimplemented read addr) or
//    (csr_write_enable & (unimplemented addr | addr[11:10]==2'b11)); the offending
//    write is dropped. Trap port never flags illegal; writes to RO/unimpl ignored.
//  - rst asserted mid-sequence overrides every write and increment that cycle.
// CONFIGURATION
//  - CSR_COUNTERS_EN defined: 64-bit mcycle (B00/B80) and minstret (B02/B82),
//    read-only aliases cycle C00/C80, instret C02/C82. mcycle +1 every cycle,
//    minstret +1 when instret_inc; both wrap 2^64-1 -> 0 with carry into high half.
//    Writing a half replaces that half only and suppresses the counter's increment
//    that cycle; the other half is unchanged. Alias writes are illegal (RO space).
//  - Not defined: those addresses are unimplemented (read 0, access illegal), no
//    counter flops synthesised.
// TESTING
//  - Reset: rst=1 one cycle -> mtvec=32'h0000_1000, mstatus=32'h0000_1800, mepc=0.
//  - Instr write mtvec=32'h8000_0003 -> next cycle read 32'h8000_0000; same-cycle
//    read still 32'h0000_1000.
//  - Trap writes mepc=32'h0000_2004 while instr writes mepc=32'hDEAD_BEEF same
//    cycle -> mepc=32'h0000_2004; csr_rd at 341 = 32'h0000_2004.
//  - Instr write to F14 or to 7C0 -> csr_illegal=1, state unchanged; read of 301
//    -> 32'h4000_0100, csr_illegal=0.
//  - CSR_COUNTERS_EN: write mcycle=32'hFFFF_FFFF, mcycleh=0 -> two cycles later
//    mcycleh=1, mcycle=32'h0000_0000 (write cycle no increment).
//  - CSR_COUNTERS_EN: instret_inc=1 for 5 cycles from reset -> minstret=5; write
//    C02 -> csr_illegal=1, minstret keeps counting.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr instruction port plus trap-controller port.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters and their read-only aliases.
module csr_file #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_1000,
   parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_read_enable,
   input  logic [11:0] csr_read_address,
   output logic [31:0] csr_read_data,
   input  logic        csr_write_enable,
   input  logic [11:0] csr_write_address,
   input  logic [31:0] csr_write_data,
   output logic        csr_illegal,
   input  logic [11:0] csr_trap_address,
   input  logic        csr_trap_write_enable,
   input  logic [31:0] csr_trap_write_data,
   output logic [31:0] csr_rd,
   input  logic        instret_inc
);

   logic        mie_q, mie_d, mpie_q, mpie_d;
   logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
   logic [31:0] mstatus_val;

   // MPP is hardwired to machine mode; only MIE/MPIE are stored.
   assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
`else
   logic unused_instret_inc;
   assign unused_instret_inc = instret_inc;
`endif

   function automatic logic is_impl(input logic [11:0] addr);
      logic hit;
      hit = 1'b0;
      case (addr)
         12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
         12'hF11, 12'hF12, 12'hF13, 12'hF14: hit = 1'b1;
`ifdef CSR_COUNTERS_EN
         12'hB00, 12'hB80, 12'hB02, 12'hB82,
         12'hC00, 12'hC80, 12'hC02, 12'hC82: hit = 1'b1;
`endif
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

   function automatic logic [31:0] csr_rdata(input logic [11:0] addr);
      logic [31:0] val;
      val = 32'h0;
      case (addr)
         12'h300: val = mstatus_val;
         12'h301: val = 32'h4000_0100;
         12'h305: val = mtvec_q;
         12'h340: val = mscratch_q;
         12'h341: val = mepc_q;
         12'h342: val = mcause_q;
         12'h343: val = mtval_q;
         12'hF14: val = HART_ID;
`ifdef CSR_COUNTERS_EN
         12'hB00, 12'hC00: val = mcycle_q[31:0];
         12'hB80, 12'hC80: val = mcycle_q[63:32];
         12'hB02, 12'hC02: val = minstret_q[31:0];
         12'hB82, 12'hC82: val = minstret_q[63:32];
`endif
         default: val = 32'h0;
      endcase
      return val;
   endfunction

   logic wr_illegal, instr_we;

   always_comb begin
      csr_read_data = csr_rdata(csr_read_address);
      csr_rd        = csr_rdata(csr_trap_address);
   end

   assign wr_illegal  = csr_write_enable &
                        (~is_impl(csr_write_address) | (csr_write_address[11:10] == 2'b11));
   assign csr_illegal = (csr_read_enable & ~is_impl(csr_read_address)) | wr_illegal;
   // Trap port takes priority on an address collision.
   assign instr_we    = csr_write_enable & ~wr_illegal &
                        ~(csr_trap_write_enable & (csr_trap_address == csr_write_address));

   always_comb begin
      logic        we;
      logic [11:0] wa;
      logic [31:0] wd;
`ifdef CSR_COUNTERS_EN
      logic cyc_lo_we, cyc_hi_we, ret_lo_we, ret_hi_we;
      logic [31:0] cyc_lo, cyc_hi, ret_lo, ret_hi;
      cyc_lo_we = 1'b0; cyc_hi_we = 1'b0; ret_lo_we = 1'b0; ret_hi_we = 1'b0;
      cyc_lo = mcycle_q[31:0];   cyc_hi = mcycle_q[63:32];
      ret_lo = minstret_q[31:0]; ret_hi = minstret_q[63:32];
`endif
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      for (int p = 0; p < 2; p++) begin
         we = (p == 0) ? instr_we : csr_trap_write_enable;
         wa = (p == 0) ? csr_write_address : csr_trap_address;
         wd = (p == 0) ? csr_write_data : csr_trap_write_data;
         if (we) begin
            case (wa)
               12'h300: begin mie_d = wd[3]; mpie_d = wd[7]; end
               12'h305: mtvec_d    = {wd[31:2], 2'b00};
               12'h340: mscratch_d = wd;
               12'h341: mepc_d     = {wd[31:2], 2'b00};
               12'h342: mcause_d   = wd;
               12'h343: mtval_d    = wd;
`ifdef CSR_COUNTERS_EN
               12'hB00: begin cyc_lo_we = 1'b1; cyc_lo = wd; end
               12'hB80: begin cyc_hi_we = 1'b1; cyc_hi = wd; end
               12'hB02: begin ret_lo_we = 1'b1; ret_lo = wd; end
               12'hB82: begin ret_hi_we = 1'b1; ret_hi = wd; end
`endif
               default: ;
            endcase
         end
      end
`ifdef CSR_COUNTERS_EN
      // Any half written this cycle suppresses that counter's increment.
      mcycle_d   = (cyc_lo_we | cyc_hi_we) ? {cyc_hi, cyc_lo} : mcycle_q + 64'd1;
      minstret_d = (ret_lo_we | ret_hi_we) ? {ret_hi, ret_lo} :
                   minstret_q + {63'd0, instret_inc};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
         mscratch_q <= 32'h0;
         mepc_q     <= 32'h0;
         mcause_q   <= 32'h0;
         mtval_q    <= 32'h0;
`ifdef CSR_COUNTERS_EN
         mcycle_q   <= 64'h0;
         minstret_q <= 64'h0;
`endif
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
`ifdef CSR_COUNTERS_EN
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
`endif
      end
   end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: stimulus queues expectations, a negedge monitor checks outputs.
// Counter checks are compiled in when CSR_COUNTERS_EN is defined.
module tb_csr_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_read_enable;
   logic [11:0] csr_read_address;
   logic [31:0] csr_read_data;
   logic        csr_write_enable;
   logic [11:0] csr_write_address;
   logic [31:0] csr_write_data;
   logic        csr_illegal;
   logic [11:0] csr_trap_address;
   logic        csr_trap_write_enable;
   logic [31:0] csr_trap_write_data;
   logic [31:0] csr_rd;
   logic        instret_inc;

   always #5 clk = ~clk;

   csr_file #(
      .MTVEC_RESET(32'h0000_1000),
      .HART_ID    (32'h0000_0007)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .csr_read_enable      (csr_read_enable),
      .csr_read_address     (csr_read_address),
      .csr_read_data        (csr_read_data),
      .csr_write_enable     (csr_write_enable),
      .csr_write_address    (csr_write_address),
      .csr_write_data       (csr_write_data),
      .csr_illegal          (csr_illegal),
      .csr_trap_address     (csr_trap_address),
      .csr_trap_write_enable(csr_trap_write_enable),
      .csr_trap_write_data  (csr_trap_write_data),
      .csr_rd               (csr_rd),
      .instret_inc          (instret_inc)
   );

   localparam int SEL_RDATA = 0;
   localparam int SEL_RD    = 1;
   localparam int SEL_ILL   = 2;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] val;
   } chk_t;

   chk_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic exp_chk(input string name, input int sel, input logic [31:0] val);
      chk_t c;
      c.name = name;
      c.sel  = sel;
      c.val  = val;
      sb.push_back(c);
   endtask

   always @(negedge clk) begin
      chk_t        c;
      logic [31:0] act;
      while (sb.size() > 0) begin
         c = sb.pop_front();
         case (c.sel)
            SEL_RDATA: act = csr_read_data;
            SEL_RD:    act = csr_rd;
            default:   act = {31'b0, csr_illegal};
         endcase
         n_checks++;
         if (act !== c.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", c.name, act, c.val);
         end
      end
   end

   task automatic idle();
      rst                   = 1'b0;
      csr_read_enable       = 1'b0;
      csr_read_address      = 12'h000;
      csr_write_enable      = 1'b0;
      csr_write_address     = 12'h000;
      csr_write_data        = 32'h0;
      csr_trap_address      = 12'h000;
      csr_trap_write_enable = 1'b0;
      csr_trap_write_data   = 32'h0;
      instret_inc           = 1'b0;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic rd(input logic [11:0] addr);
      csr_read_enable  = 1'b1;
      csr_read_address = addr;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] data);
      csr_write_enable  = 1'b1;
      csr_write_address = addr;
      csr_write_data    = data;
   endtask

   task automatic twr(input logic [11:0] addr, input logic [31:0] data);
      csr_trap_address      = addr;
      csr_trap_write_enable = 1'b1;
      csr_trap_write_data   = data;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      next();
      // Post-reset state
      rd(12'h305); csr_trap_address = 12'h300;
      exp_chk("reset_mtvec", SEL_RDATA, 32'h0000_1000);
      exp_chk("reset_mstatus", SEL_RD, 32'h0000_1800);
      exp_chk("reset_illegal", SEL_ILL, 32'h0);
      next();
      csr_trap_address = 12'h341;
      exp_chk("reset_mepc", SEL_RD, 32'h0);
      next();
      wr(12'h305, 32'h8000_0003); rd(12'h305);
      exp_chk("mtvec_same_cycle", SEL_RDATA, 32'h0000_1000);
      next();
      rd(12'h305);
      exp_chk("mtvec_aligned", SEL_RDATA, 32'h8000_0000);
      next();
      twr(12'h341, 32'h0000_2004); wr(12'h341, 32'hDEAD_BEEF);
      exp_chk("mepc_no_bypass", SEL_RD, 32'h0);
      next();
      csr_trap_address = 12'h341; rd(12'h341);
      exp_chk("mepc_trap_wins_rd", SEL_RD, 32'h0000_2004);
      exp_chk("mepc_trap_wins_rdata", SEL_RDATA, 32'h0000_2004);
      next();
      wr(12'hF14, 32'h5);
      exp_chk("illegal_wr_mhartid", SEL_ILL, 32'h1);
      next();
      wr(12'h7C0, 32'h5); csr_trap_address = 12'hF14;
      exp_chk("illegal_wr_unimpl", SEL_ILL, 32'h1);
      exp_chk("mhartid_unchanged", SEL_RD, 32'h0000_0007);
      next();
      rd(12'h301); csr_trap_address = 12'h7C0;
      exp_chk("misa_value", SEL_RDATA, 32'h4000_0100);
      exp_chk("misa_legal", SEL_ILL, 32'h0);
      exp_chk("unimpl_reads_zero", SEL_RD, 32'h0);
      next();
      wr(12'h300, 32'hFFFF_FFFF); twr(12'h342, 32'h8000_000B);
      next();
      rd(12'h300); csr_trap_address = 12'h342;
      exp_chk("mstatus_mask", SEL_RDATA, 32'h0000_1888);
      exp_chk("mcause_both_commit", SEL_RD, 32'h8000_000B);
      next();
      rd(12'h7C0);
      exp_chk("unimpl_rdata", SEL_RDATA, 32'h0);
      exp_chk("illegal_rd_unimpl", SEL_ILL, 32'h1);
      next();
      // Reset overrides writes issued in the same cycle
      rst = 1'b1; wr(12'h340, 32'h1234_5678); twr(12'h341, 32'h55);
      exp_chk("pre_reset_mepc", SEL_RD, 32'h0000_2004);
      next();
      rd(12'h340); csr_trap_address = 12'h341;
      exp_chk("rst_mscratch", SEL_RDATA, 32'h0);
      exp_chk("rst_mepc", SEL_RD, 32'h0);
      next();
      rd(12'h305); csr_trap_address = 12'h300;
      exp_chk("rst_mtvec", SEL_RDATA, 32'h0000_1000);
      exp_chk("rst_mstatus", SEL_RD, 32'h0000_1800);
      next();
`ifdef CSR_COUNTERS_EN
      rst = 1'b1;
      next();
      for (int i = 0; i < 5; i++) begin
         instret_inc = 1'b1;
         if (i == 2) begin
            wr(12'hC02, 32'h0);
            exp_chk("illegal_wr_instret", SEL_ILL, 32'h1);
         end
         next();
      end
      rd(12'hB02); csr_trap_address = 12'hB00;
      exp_chk("minstret_5", SEL_RDATA, 32'h5);
      exp_chk("mcycle_5", SEL_RD, 32'h5);
      next();
      rd(12'hC02); csr_trap_address = 12'hC00; wr(12'hB00, 32'hFFFF_FFFF);
      exp_chk("instret_alias", SEL_RDATA, 32'h5);
      exp_chk("cycle_alias", SEL_RD, 32'h6);
      next();
      wr(12'hB80, 32'h0); csr_trap_address = 12'hB00;
      exp_chk("mcycle_lo_written", SEL_RD, 32'hFFFF_FFFF);
      next();
      rd(12'hB00); csr_trap_address = 12'hB80;
      exp_chk("mcycle_no_inc", SEL_RDATA, 32'hFFFF_FFFF);
      exp_chk("mcycleh_written", SEL_RD, 32'h0);
      next();
      rd(12'hB00); csr_trap_address = 12'hB80;
      exp_chk("mcycle_wrap_lo", SEL_RDATA, 32'h0);
      exp_chk("mcycle_carry_hi", SEL_RD, 32'h1);
      next();
`else
      rd(12'hB00);
      exp_chk("no_counter_rdata", SEL_RDATA, 32'h0);
      exp_chk("no_counter_illegal", SEL_ILL, 32'h1);
      next();
`endif
      @(negedge clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
